// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM:
// opcodes, functs, ALU op codes, FSM states and instruction classes.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        S_ENTRY, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    typedef enum logic [2:0] {
        CL_RTYPE, CL_IMM, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP, CL_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational decode of the latched opcode/funct into an instruction
// class and the ALU op the datapath should use for it.
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic [2:0] alu_op
);

    always_comb begin
        iclass = CL_ILLEGAL;
        alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin iclass = CL_RTYPE; alu_op = ALU_ADD; end
                    FN_SUB:  begin iclass = CL_RTYPE; alu_op = ALU_SUB; end
                    FN_AND:  begin iclass = CL_RTYPE; alu_op = ALU_AND; end
                    FN_OR:   begin iclass = CL_RTYPE; alu_op = ALU_OR;  end
                    FN_SLT:  begin iclass = CL_RTYPE; alu_op = ALU_SLT; end
                    default: iclass = CL_ILLEGAL;
                endcase
            end
            OP_ADDI:        iclass = CL_IMM;
            OP_LW:          iclass = CL_LOAD;
            OP_SW:          iclass = CL_STORE;
            OP_BEQ, OP_BNE: begin iclass = CL_BRANCH; alu_op = ALU_SUB; end
            OP_J:           iclass = CL_JUMP;
            default:        iclass = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM: ENTRY/FETCH/DECODE/EXEC/MEM/WB sequencing,
// interrupt entry at instruction boundaries, sticky illegal flag, retire counter.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ENTRY_PC = 128,
    parameter int CNT_W    = 32,
    parameter int ALUOP_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        ins,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               zero,
    input  logic               irq,
    output logic               ir_write,
    output logic               pc_write,
    output logic               INT,
    output logic [31:0]        entryPoint,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrc,
    output logic               Mem2Reg,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [ALUOP_W-1:0] op,
    output logic               branch,
    output logic               branch_ne,
    output logic               jump,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_count
);

    // Ready semantics: imem_ready marks the cycle ins is valid and is consumed
    // only in S_FETCH; dmem_ready marks the cycle the pending access completes,
    // and MemRead/MemWrite stay high up to and including that cycle.

    state_t           state, state_next;
    logic [5:0]       opcode_q, funct_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic             latch_ir, retire, set_illegal;
    iclass_t          iclass;
    logic [2:0]       dec_op;

    // zero is consumed by yPC for branch target selection, not here.
    logic unused_inputs;
    assign unused_inputs = ^{ins[25:6], zero};

    mc_ctrl_dec u_dec (
        .opcode (opcode_q),
        .funct  (funct_q),
        .iclass (iclass),
        .alu_op (dec_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_ENTRY;
            opcode_q  <= '0;
            funct_q   <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state <= state_next;
            if (latch_ir) begin
                opcode_q <= ins[31:26];
                funct_q  <= ins[5:0];
            end
            if (set_illegal) illegal_q <= 1'b1;
            if (retire)      cnt_q     <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_next  = state;
        latch_ir    = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        INT         = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrc      = 1'b0;
        Mem2Reg     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        op          = '0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        jump        = 1'b0;
        if (!rst) begin
            case (state)
                S_ENTRY: begin
                    INT        = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_FETCH;
                end
                S_FETCH: begin
                    // irq is only honoured here, so no instruction is ever split.
                    if (irq) begin
                        state_next = S_ENTRY;
                    end else if (imem_ready) begin
                        ir_write   = 1'b1;
                        latch_ir   = 1'b1;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (iclass)
                        CL_JUMP: begin
                            jump       = 1'b1;
                            pc_write   = 1'b1;
                            retire     = 1'b1;
                            state_next = S_FETCH;
                        end
                        CL_ILLEGAL: begin
                            set_illegal = 1'b1;
                            pc_write    = 1'b1;
                            state_next  = S_FETCH;
                        end
                        default: state_next = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    ALUSrc = (iclass != CL_RTYPE) && (iclass != CL_BRANCH);
                    op     = ALUOP_W'(dec_op);
                    case (iclass)
                        CL_RTYPE, CL_IMM:  state_next = S_WB;
                        CL_LOAD, CL_STORE: state_next = S_MEM;
                        default: begin
                            branch     = 1'b1;
                            branch_ne  = (opcode_q == OP_BNE);
                            pc_write   = 1'b1;
                            retire     = 1'b1;
                            state_next = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    ALUSrc = 1'b1;
                    op     = ALUOP_W'(dec_op);
                    if (iclass == CL_LOAD) begin
                        MemRead = 1'b1;
                        if (dmem_ready) state_next = S_WB;
                    end else begin
                        MemWrite = 1'b1;
                        if (dmem_ready) begin
                            pc_write   = 1'b1;
                            retire     = 1'b1;
                            state_next = S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    ALUSrc     = (iclass != CL_RTYPE);
                    op         = ALUOP_W'(dec_op);
                    RegWrite   = 1'b1;
                    RegDst     = (iclass == CL_RTYPE);
                    Mem2Reg    = (iclass == CL_LOAD);
                    pc_write   = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                default: state_next = S_ENTRY;
            endcase
        end
    end

    assign entryPoint  = 32'(ENTRY_PC);
    assign illegal     = illegal_q & ~rst;
    assign instr_count = rst ? '0 : cnt_q;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main control FSM for the MIPS-subset datapath (yIF/yPC/yID/yEX/yDM/yWB). It replaces the per-instruction control decoding done in the testbench.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction, with ready handshakes to instruction and data memory.
- Adds interrupt entry at instruction boundaries, bne/sub/and/slt support, illegal-opcode flagging and a retired-instruction counter.

Parameters:
- ENTRY_PC, 128: interrupt/reset entry address, driven on entryPoint.
- CNT_W, 32: width of retired-instruction counter.
- ALUOP_W, 3: width of op.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- ins  in  32  instruction from IF stage.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data memory access completes this cycle.
- zero  in  1  ALU zero flag from EX.
- irq  in  1  interrupt request, level.
- ir_write  out  1  latch ins into IR.
- pc_write  out  1  PC update strobe.
- INT  out  1  PC selects entryPoint.
- entryPoint  out  32  constant ENTRY_PC.
- RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite  out  1 each  datapath controls, same meaning as existing labs.
- op  out  ALUOP_W  ALU op: and=000, or=001, add=010, sub=110, slt=111.
- branch  out  1  conditional branch active.
- branch_ne  out  1  branch taken on !zero (bne), else on zero.
- jump  out  1  PC selects jTarget.
- illegal  out  1  sticky illegal-instruction flag.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- States: S_ENTRY, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB. Outputs are Moore, decoded from state and latched opcode/funct.
- Reset: while rst=1, state<=S_ENTRY, opcode/funct regs<=0, illegal<=0, instr_count<=0, and all outputs gated to 0 except entryPoint. Reset mid-instruction aborts it with no RegWrite/MemWrite in the reset cycle.
- S_ENTRY (1 cycle): INT=1, pc_write=1 -> S_FETCH.
- S_FETCH:
  - Sampled first: if irq=1 -> S_ENTRY, no fetch.
  - Else wait for imem_ready. On imem_ready=1: ir_write=1, latch ins[31:26], ins[5:0] -> S_DECODE.
  - Stall indefinitely otherwise.
- S_DECODE:
  - j (2): jump=1, pc_write=1, count++ -> S_FETCH.
  - Unknown opcode, or R-type with funct not in {20,22,24,25,2a}: illegal<=1, pc_write=1 (PC+4), count NOT incremented -> S_FETCH.
  - Else -> S_EXEC.
- S_EXEC:
  - R-type: ALUSrc=0, op from funct (20->010, 22->110, 24->000, 25->001, 2a->111) -> S_WB.
  - addi (8): ALUSrc=1, op=010 -> S_WB.
  - lw (23) / sw (2b): ALUSrc=1, op=010 -> S_MEM.
  - beq (4) / bne (5): ALUSrc=0, op=110, branch=1, branch_ne=(opcode==5), pc_write=1, count++ -> S_FETCH. Target selection is done in yPC from zero.
- S_MEM: ALUSrc=1, op=010 held stable.
  - lw: MemRead=1 until dmem_ready; on ready -> S_WB.
  - sw: MemWrite=1 until dmem_ready; on ready: pc_write=1, count++ -> S_FETCH.
- S_WB (1 cycle): RegWrite=1, pc_write=1, count++ -> S_FETCH.
  - R-type: RegDst=1, Mem2Reg=0.
  - addi: RegDst=0, Mem2Reg=0.
  - lw: RegDst=0, Mem2Reg=1; ALUSrc/op held from EXEC.
- Latency with zero-wait memory, counted from the cycle the instruction is fetched:
  - j: 2 cycles.
  - beq/bne: 3 cycles.
  - R-type/addi: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - Each cycle with dmem_ready=0 in S_MEM adds one.
- irq arriving mid-instruction is not taken until the next S_FETCH; no instruction is ever partially executed.
- instr_count wraps modulo 2^CNT_W.
- illegal is cleared only by rst.

Decomposition:
- Package mc_ctrl_pkg: opcode constants (OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_BNE=5, OP_ADDI=8, OP_LW=23h, OP_SW=2Bh), funct constants, ALU op codes, and the state enum.
- Sub-module mc_ctrl_dec: combinational decode of opcode/funct to class (RTYPE/IMM/LOAD/STORE/BRANCH/JUMP/ILLEGAL) and ALU op. The FSM uses only the class.

Test Plan:
- Reset, then release with imem_ready=1 -> cycle 1 INT=1, pc_write=1; cycle 2 ir_write=1; instr_count=0.
- add (ins=00a62020h), imem_ready=1 -> EXEC op=010 ALUSrc=0; WB RegDst=1 RegWrite=1 pc_write=1; instr_count=1 after 4 cycles.
- lw (8c0a0004h) with dmem_ready low for 3 MEM cycles -> MemRead=1 for 4 cycles, RegWrite=1 and Mem2Reg=1 only after ready; total 8 cycles.
- bne (14850003h) with zero=0 -> EXEC branch=1, branch_ne=1, pc_write=1; no RegWrite/MemWrite; next state FETCH.
- irq=1 raised during an sw in S_MEM -> sw completes with MemWrite until ready, then S_ENTRY with INT=1, then fetch.
- Opcode 3Fh -> illegal=1 sticky, pc_write=1, instr_count unchanged. rst pulse in S_MEM of sw -> MemWrite=0 in the reset cycle; illegal=0, count=0, INT=1 on the first post-reset cycle.
